// File: rtl/idex_skid_reg.sv
// rtl/idex_skid_reg.sv - decode-to-execute pipeline register with 2-entry skid buffer
module idex_skid_reg #(
    parameter int                 XLEN      = 32,
    parameter int                 CTRL_W    = 21,
    parameter int                 REG_AW    = 5,
    parameter logic [CTRL_W-1:0]  KILL_MASK = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [CTRL_W-1:0] i_ctrl_d,
    input  logic [XLEN-1:0]   i_rd1_d,
    input  logic [XLEN-1:0]   i_rd2_d,
    input  logic [XLEN-1:0]   i_imm_d,
    input  logic [XLEN-1:0]   i_upimm_d,
    input  logic [XLEN-1:0]   i_pc_d,
    input  logic [XLEN-1:0]   i_pcplus4_d,
    input  logic [REG_AW-1:0] i_rs1_d,
    input  logic [REG_AW-1:0] i_rs2_d,
    input  logic [REG_AW-1:0] i_rd_d,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [CTRL_W-1:0] o_ctrl_e,
    output logic [XLEN-1:0]   o_rd1_e,
    output logic [XLEN-1:0]   o_rd2_e,
    output logic [XLEN-1:0]   o_imm_e,
    output logic [XLEN-1:0]   o_upimm_e,
    output logic [XLEN-1:0]   o_pc_e,
    output logic [XLEN-1:0]   o_pcplus4_e,
    output logic [REG_AW-1:0] o_rs1_e,
    output logic [REG_AW-1:0] o_rs2_e,
    output logic [REG_AW-1:0] o_rd_e
);

    localparam int PW = CTRL_W + 6 * XLEN + 3 * REG_AW;

    // State bits are {M.valid, S.valid}; 2'b01 cannot be reached.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [PW-1:0]     r_m_pay;
    logic [PW-1:0]     r_s_pay;
    logic [PW-1:0]     w_pay_d;
    logic [CTRL_W-1:0] w_m_ctrl;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_drain;
    logic              w_ld_m_in;
    logic              w_ld_m_s;
    logic              w_ld_s_in;

    assign w_pay_d = {i_ctrl_d, i_rd1_d, i_rd2_d, i_imm_d, i_upimm_d, i_pc_d,
                      i_pcplus4_d, i_rs1_d, i_rs2_d, i_rd_d};

    assign {w_m_ctrl, o_rd1_e, o_rd2_e, o_imm_e, o_upimm_e, o_pc_e,
            o_pcplus4_e, o_rs1_e, o_rs2_e, o_rd_e} = r_m_pay;

    // Ready depends only on the skid valid bit and reset, never on the consumer side.
    assign w_in_ready = !r_state[0] && !i_reset;
    assign w_accept   = i_in_valid && w_in_ready;
    assign w_drain    = r_state[1] && i_out_ready;

    // State register: valid bits of the main and skid entries.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and payload-load selection; flush overrides every transition.
    always_comb begin
        w_next_state = r_state;
        w_ld_m_in    = 1'b0;
        w_ld_m_s     = 1'b0;
        w_ld_s_in    = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_next_state = ST_ONE;
                    w_ld_m_in    = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_drain && w_accept) begin
                    w_ld_m_in = 1'b1;
                end else if (w_drain) begin
                    w_next_state = ST_EMPTY;
                end else if (w_accept) begin
                    w_next_state = ST_FULL;
                    w_ld_s_in    = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_drain) begin
                    w_next_state = ST_ONE;
                    w_ld_m_s     = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_EMPTY;
            end
        endcase
        if (i_flush) begin
            w_next_state = ST_EMPTY;
            w_ld_m_in    = 1'b0;
            w_ld_m_s     = 1'b0;
            w_ld_s_in    = 1'b0;
        end
    end

    // Payload registers change only on a load so held entries stay glitch-free.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_m_pay <= '0;
            r_s_pay <= '0;
        end else begin
            if (w_ld_m_in) begin
                r_m_pay <= w_pay_d;
            end else if (w_ld_m_s) begin
                r_m_pay <= r_s_pay;
            end
            if (w_ld_s_in) begin
                r_s_pay <= w_pay_d;
            end
        end
    end

    // Handshake outputs and bubble masking of side-effecting control bits.
    always_comb begin
        o_in_ready  = w_in_ready;
        o_out_valid = r_state[1];
        o_ctrl_e    = w_m_ctrl & ~(KILL_MASK & {CTRL_W{!r_state[1]}});
    end

endmodule

// File: tb/tb_idex_skid_reg.sv
// tb/tb_idex_skid_reg.sv - scoreboard bench for idex_skid_reg
module tb_idex_skid_reg;

    localparam int XLEN   = 64;
    localparam int CTRL_W = 21;
    localparam int REG_AW = 6;
    // MemWrite=20, RegWrite=17, Jump=1, Branch=0
    localparam logic [CTRL_W-1:0] KMASK    = (21'd1 << 20) | (21'd1 << 17) | 21'd3;
    localparam logic [CTRL_W-1:0] CTRL_ALL = '1;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   upimm;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pcplus4;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } pay_t;

    logic clk;
    logic reset;
    logic flush;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    pay_t din;
    pay_t dout;

    logic [CTRL_W-1:0] ctrl_e;
    logic [XLEN-1:0]   rd1_e, rd2_e, imm_e, upimm_e, pc_e, pcplus4_e;
    logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;

    assign dout = {ctrl_e, rd1_e, rd2_e, imm_e, upimm_e, pc_e, pcplus4_e, rs1_e, rs2_e, rd_e};

    idex_skid_reg #(
        .XLEN(XLEN), .CTRL_W(CTRL_W), .REG_AW(REG_AW), .KILL_MASK(KMASK)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_ctrl_d(din.ctrl), .i_rd1_d(din.rd1), .i_rd2_d(din.rd2), .i_imm_d(din.imm),
        .i_upimm_d(din.upimm), .i_pc_d(din.pc), .i_pcplus4_d(din.pcplus4),
        .i_rs1_d(din.rs1), .i_rs2_d(din.rs2), .i_rd_d(din.rd),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_ctrl_e(ctrl_e), .o_rd1_e(rd1_e), .o_rd2_e(rd2_e), .o_imm_e(imm_e),
        .o_upimm_e(upimm_e), .o_pc_e(pc_e), .o_pcplus4_e(pcplus4_e),
        .o_rs1_e(rs1_e), .o_rs2_e(rs2_e), .o_rd_e(rd_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    pay_t q[$];
    pay_t popped;
    pay_t got;
    bit   drained;

    function automatic pay_t rnd_pay();
        pay_t p;
        p.ctrl    = CTRL_W'($urandom);
        p.rd1     = {$urandom, $urandom};
        p.rd2     = {$urandom, $urandom};
        p.imm     = {$urandom, $urandom};
        p.upimm   = {$urandom, $urandom};
        p.pc      = {$urandom, $urandom};
        p.pcplus4 = {$urandom, $urandom};
        p.rs1     = REG_AW'($urandom);
        p.rs2     = REG_AW'($urandom);
        p.rd      = REG_AW'($urandom);
        return p;
    endfunction

    // Scoreboard bookkeeping for the coming edge, then advance one cycle.
    task automatic step();
        @(negedge clk);
        drained = 1'b0;
        if (reset || flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() > 0) popped = q.pop_front();
                else popped = 'x;
                got     = dout;
                drained = 1'b1;
            end
            if (in_valid && in_ready) q.push_back(din);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        din = rnd_pay();
        step();
        din = rnd_pay();
        step();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
        end
        n_tests++;
        if (dout !== '0) begin
            n_fail++;
            $display("FAIL reset_data got=%h want 0", dout);
        end
        reset = 1'b0; in_valid = 1'b0;
        step();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || ctrl_e !== '0) begin
            n_fail++;
            $display("FAIL reset_release in_ready=%b out_valid=%b ctrl_e=%h want 1 0 0", in_ready, out_valid, ctrl_e);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = rnd_pay();
            din.pc = XLEN'(i * 4);
            in_valid = 1'b1;
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready i=%0d got=%b want 1", i, in_ready);
            end
            step();
            n_tests++;
            if (out_valid !== 1'b1 || pc_e !== XLEN'(i * 4)) begin
                n_fail++;
                $display("FAIL stream_latency i=%0d out_valid=%b pc_e=%h want 1 %h", i, out_valid, pc_e, i * 4);
            end
            if (drained) begin
                n_tests++;
                if (got !== popped) begin
                    n_fail++;
                    $display("FAIL stream_data got=%h want=%h", got, popped);
                end
            end
        end
        in_valid = 1'b0;
        step();
        n_tests++;
        if (!drained || got !== popped || got.pc !== 64'hC || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_last drained=%b pc=%h out_valid=%b want 1 c 0", drained, got.pc, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [XLEN-1:0] dl[$];
        out_ready = 1'b0;
        din = rnd_pay(); din.pc = 64'h100; in_valid = 1'b1;
        step();
        din = rnd_pay(); din.pc = 64'h104;
        step();
        din = rnd_pay(); din.pc = 64'h108;
        step();
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || pc_e !== 64'h100) begin
            n_fail++;
            $display("FAIL bp_full in_ready=%b out_valid=%b pc_e=%h want 0 1 100", in_ready, out_valid, pc_e);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!in_valid || in_ready === 1'b0) begin
            end
            if (drained) begin
                dl.push_back(got.pc);
                n_tests++;
                if (got !== popped) begin
                    n_fail++;
                    $display("FAIL bp_data got=%h want=%h", got, popped);
                end
            end
            if (q.size() == 0 && dl.size() == 2) in_valid = 1'b0;
            if (dl.size() == 2 && q.size() == 1) in_valid = 1'b0;
        end
        n_tests++;
        if (dl.size() != 3) begin
            n_fail++;
            $display("FAIL bp_count got=%0d want 3", dl.size());
        end else begin
            n_tests++;
            if (dl[0] !== 64'h100 || dl[1] !== 64'h104 || dl[2] !== 64'h108) begin
                n_fail++;
                $display("FAIL bp_order got=%h %h %h want 100 104 108", dl[0], dl[1], dl[2]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush_full();
        bit seen;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din = rnd_pay(); din.ctrl = CTRL_ALL;
        step();
        din = rnd_pay(); din.ctrl = CTRL_ALL;
        step();
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_setup in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
        end
        din = rnd_pay(); din.ctrl = CTRL_ALL;
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || (ctrl_e & KMASK) !== '0) begin
            n_fail++;
            $display("FAIL flush_state out_valid=%b in_ready=%b ctrl_e=%h want 0 1 masked", out_valid, in_ready, ctrl_e);
        end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (drained || out_valid !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush_leak got=1 want 0");
        end
    endtask

    task automatic test_kill_mask();
        pay_t last;
        out_ready = 1'b1;
        din = rnd_pay(); din.ctrl = CTRL_ALL; in_valid = 1'b1;
        last = din;
        step();
        n_tests++;
        if (out_valid !== 1'b1 || ctrl_e !== CTRL_ALL) begin
            n_fail++;
            $display("FAIL kill_valid out_valid=%b ctrl_e=%h want 1 %h", out_valid, ctrl_e, CTRL_ALL);
        end
        in_valid = 1'b0;
        step();
        n_tests++;
        if (out_valid !== 1'b0 || ctrl_e !== (CTRL_ALL & ~KMASK) || pc_e !== last.pc) begin
            n_fail++;
            $display("FAIL kill_bubble out_valid=%b ctrl_e=%h pc_e=%h want 0 %h %h",
                     out_valid, ctrl_e, pc_e, CTRL_ALL & ~KMASK, last.pc);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1;
        din = rnd_pay(); step();
        din = rnd_pay(); step();
        reset = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || dout !== '0) begin
            n_fail++;
            $display("FAIL reset_mid out_valid=%b in_ready=%b dout=%h want 0 0 0", out_valid, in_ready, dout);
        end
        reset = 1'b0; in_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        int bad_data = 0, bad_hs = 0, bad_front = 0, bad_state = 0;
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            din       = rnd_pay();
            step();
            if (drained && got !== popped) bad_data++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) bad_hs++;
            if (out_valid === 1'b1 && q.size() > 0 && dout !== q[0]) bad_front++;
            if (out_valid === 1'b0 && in_ready === 1'b0) bad_state++;
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (drained && got !== popped) bad_data++;
        end
        n_tests++;
        if (bad_data != 0) begin
            n_fail++;
            $display("FAIL rand_data errors=%0d want 0", bad_data);
        end
        n_tests++;
        if (bad_hs != 0) begin
            n_fail++;
            $display("FAIL rand_handshake errors=%0d want 0", bad_hs);
        end
        n_tests++;
        if (bad_front != 0) begin
            n_fail++;
            $display("FAIL rand_outputs errors=%0d want 0", bad_front);
        end
        n_tests++;
        if (bad_state != 0) begin
            n_fail++;
            $display("FAIL rand_state01 count=%0d want 0", bad_state);
        end
        n_tests++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_empty left=%0d out_valid=%b want 0 0", q.size(), out_valid);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        din = '0;
        popped = '0; got = '0; drained = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_kill_mask();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
